// File: rtl/mul_seq.sv
// mul_seq: shift-and-add sequential multiplier, low N bits of opA*opB.
// Optional macro MUL_SEQ_EARLY_EXIT_EN ends RUN once no multiplier bits remain.
module mul_seq #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] opA,
    input  logic [N-1:0] opB,
    output logic         busy,
    output logic         stall,
    output logic         done,
    output logic [N-1:0] product
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  mcand;
    logic [N-1:0]  mplier;
    logic [N-1:0]  acc;
    logic [N-1:0]  acc_add;
    logic [CW-1:0] cnt;
    logic          last;

    assign acc_add = mplier[0] ? acc + mcand : acc;

`ifdef MUL_SEQ_EARLY_EXIT_EN
    assign last = (cnt == CW'(N - 1)) || ((mplier >> 1) == '0);
`else
    assign last = cnt == CW'(N - 1);
`endif

    assign busy  = state != IDLE;
    assign done  = state == DONE;
    assign stall = (state == IDLE && start) || state == RUN;

    // FSM and datapath: latch on accept, one shift-add per RUN cycle, publish on exit
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= opA;
                        mplier <= opB;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_add;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= last ? cnt : cnt + 1'b1;
                    if (last) begin
                        product <= acc_add;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter: N, default 64, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 opA  input  N  multiplicand (readData1 of the execute stage).
REQ-006 opB  input  N  multiplier (readData2 of the execute stage).
REQ-007 busy  output  1  high while state != IDLE.
REQ-008 stall  output  1  combinational; high when (IDLE and start) or RUN; freezes upstream pipeline registers.
REQ-009 done  output  1  one-cycle pulse, high exactly in DONE.
REQ-010 product  output  N  low N bits of opA*opB; registered; holds value until the next accepted start.

Function
REQ-011 FSM shall have exactly three states, IDLE, RUN and DONE.
REQ-012 IDLE with start=1: latch mcand<=opA, mplier<=opB, acc<=0, cnt<=0; next state RUN.
REQ-013 IDLE with start=0: hold all registers; stay IDLE.
REQ-014 RUN, each cycle: if mplier[0]=1 then acc<=acc+mcand, else acc holds; mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
REQ-015 All adds are modulo 2^N; carry-out is discarded; operands are treated as unsigned (low N bits are identical for two's complement).
REQ-016 RUN exits to DONE after the iteration where cnt=N-1, so there are exactly N RUN cycles (see REQ-024 for the early-exit variant).
REQ-017 On the RUN->DONE transition, product<=final acc value including that cycle's add.
REQ-018 DONE lasts exactly one cycle: done=1, stall=0; next state IDLE unconditionally.
REQ-019 start asserted in RUN or DONE shall be ignored, not queued; it is accepted at the first IDLE cycle where it is high.
REQ-020 Latency without early exit: start sampled at edge t -> done high in the cycle after edge t+N -> back in IDLE after edge t+N+1.
REQ-021 cnt shall be ceil(log2(N)) bits wide and shall never wrap during an operation.

Reset
REQ-022 reset=1 at a clock edge forces state=IDLE, product=0, acc=0, mcand=0, mplier=0, cnt=0 in any state; done, busy and stall are 0 the following cycle.
REQ-023 reset takes priority over start on the same edge; an in-flight multiply is discarded with no done pulse.

Configuration
REQ-024 Macro MUL_SEQ_EARLY_EXIT_EN, when defined: RUN also exits to DONE when the shifted multiplier value (mplier>>1) is zero.
- RUN cycle count becomes max(1, index of the highest set bit of opB + 1).
- opB=0 gives exactly 1 RUN cycle and product=0.
REQ-025 Without MUL_SEQ_EARLY_EXIT_EN: exactly N RUN cycles for every operand value; no zero-detect logic is synthesised.

Verification
REQ-026 Reset, then start with opA=3, opB=5 (N=64): stall=1 for 65 cycles, then done pulses once with product=15. With MUL_SEQ_EARLY_EXIT_EN, done follows 3 RUN cycles.
REQ-027 opA=0xFFFFFFFFFFFFFFFF, opB=2 -> product=0xFFFFFFFFFFFFFFFE (modulo wrap); opA=2^63, opB=2 -> product=0.
REQ-028 opB=0, opA=123 -> product=0; with MUL_SEQ_EARLY_EXIT_EN, exactly 1 RUN cycle.
REQ-029 start held high continuously: operations proceed back-to-back with one IDLE cycle between a done pulse and the next RUN. opA/opB changes during RUN (e.g. to 7,7) shall not affect the in-flight product 3*5=15.
REQ-030 reset asserted at the 10th RUN cycle together with start=1: next cycle IDLE, product=0, done never pulses. A subsequent start with opA=6, opB=7 yields product=42.
